// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - round-robin arbiter sharing one camera I2C master between NREQ requesters
module i2c_cmd_arbiter #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [24*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]      req_rh_wl,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_done,
    output logic                 rsp_err,
    output logic [7:0]           rsp_data_r,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 i2c_exec,
    output logic [23:0]          i2c_data,
    output logic                 i2c_rh_wl,
    input  logic                 i2c_done,
    input  logic [7:0]           i2c_data_r
);

    // A zero timeout disables the watchdog; keep a 1-bit timer so the logic stays legal.
    localparam int            TW     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
    localparam logic [TW-1:0] T_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t         state, state_n;
    logic [2:0]     last, last_n;
    logic [TW-1:0]  timer, timer_n;
    logic [2:0]     grant_n;
    logic [NREQ-1:0] ready_n, done_n;
    logic           err_n;
    logic [7:0]     rdata_n;
    logic           exec_n;
    logic [23:0]    data_n;
    logic           rh_n;
    logic           busy_n;

    logic           pick_found;
    logic [2:0]     pick_id;
    logic [23:0]    pick_data;
    logic           pick_rh;
    logic [NREQ-1:0] pick_hot, grant_hot;

    // Round-robin search: first pending requester after the last one served, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        pick_data  = '0;
        pick_rh    = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pick_found && req_valid[i] && (i == (int'(last) + k) % NREQ)) begin
                    pick_found = 1'b1;
                    pick_id    = 3'(i);
                    pick_data  = req_data[24*i +: 24];
                    pick_rh    = req_rh_wl[i];
                end
            end
        end
    end

    // One-hot views of the candidate and of the current owner for the pulse outputs.
    always_comb begin
        pick_hot  = '0;
        grant_hot = '0;
        for (int i = 0; i < NREQ; i++) begin
            pick_hot[i]  = (i == int'(pick_id));
            grant_hot[i] = (i == int'(grant_id));
        end
    end

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_n = state;
        last_n  = last;
        timer_n = timer;
        grant_n = grant_id;
        ready_n = '0;
        done_n  = '0;
        err_n   = rsp_err;
        rdata_n = rsp_data_r;
        exec_n  = 1'b0;
        data_n  = i2c_data;
        rh_n    = i2c_rh_wl;
        busy_n  = busy;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    ready_n = pick_hot;
                    data_n  = pick_data;
                    rh_n    = pick_rh;
                    grant_n = pick_id;
                    last_n  = pick_id;
                    busy_n  = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                exec_n  = 1'b1;
                timer_n = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (timer != T_MAX) begin
                    timer_n = timer + 1'b1;
                end
                // A completion on the timeout cycle still counts as success.
                if (i2c_done) begin
                    done_n  = grant_hot;
                    err_n   = 1'b0;
                    rdata_n = i2c_rh_wl ? i2c_data_r : 8'h00;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end else if ((TIMEOUT_CYC != 0) && (timer == T_LAST)) begin
                    done_n  = grant_hot;
                    err_n   = 1'b1;
                    rdata_n = 8'h00;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last       <= 3'(NREQ - 1);
            timer      <= '0;
            grant_id   <= '0;
            req_ready  <= '0;
            rsp_done   <= '0;
            rsp_err    <= 1'b0;
            rsp_data_r <= '0;
            i2c_exec   <= 1'b0;
            i2c_data   <= '0;
            i2c_rh_wl  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            last       <= last_n;
            timer      <= timer_n;
            grant_id   <= grant_n;
            req_ready  <= ready_n;
            rsp_done   <= done_n;
            rsp_err    <= err_n;
            rsp_data_r <= rdata_n;
            i2c_exec   <= exec_n;
            i2c_data   <= data_n;
            i2c_rh_wl  <= rh_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb/tb_i2c_cmd_arbiter.sv - self-checking bench for i2c_cmd_arbiter
module tb_i2c_cmd_arbiter;

    localparam int NREQ = 3;
    localparam int TMO  = 100;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       valid = '0;
    logic [NREQ-1:0][23:0] cmd   = '0;
    logic [NREQ-1:0]       rh    = '0;
    logic [NREQ-1:0]       req_ready, rsp_done;
    logic                  rsp_err;
    logic [7:0]            rsp_data_r;
    logic                  busy;
    logic [2:0]            grant_id;
    logic                  i2c_exec;
    logic [23:0]           i2c_data;
    logic                  i2c_rh_wl;
    logic                  i2c_done   = 1'b0;
    logic [7:0]            i2c_data_r = '0;

    int npass  = 0;
    int ntot   = 0;
    int cyc    = 0;
    int m_last = NREQ - 1;

    i2c_cmd_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (valid),
        .req_data   (cmd),
        .req_rh_wl  (rh),
        .req_ready  (req_ready),
        .rsp_done   (rsp_done),
        .rsp_err    (rsp_err),
        .rsp_data_r (rsp_data_r),
        .busy       (busy),
        .grant_id   (grant_id),
        .i2c_exec   (i2c_exec),
        .i2c_data   (i2c_data),
        .i2c_rh_wl  (i2c_rh_wl),
        .i2c_done   (i2c_done),
        .i2c_data_r (i2c_data_r)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference arbitration: first requester after the last winner, modulo NREQ.
    function automatic int pick(input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    // One full transaction starting in an IDLE cycle with a request pending.
    // lat: cycles from the exec cycle to i2c_done (<0 or >=TMO: never driven).
    // mode: 0 drop request after grant, 1 keep it, 2 re-roll it randomly.
    task automatic txn(input int lat, input logic [7:0] rdata, input int mode,
                       input bit done_in_issue, output int g, output int ecyc);
        logic [23:0] ecmd;
        logic        erh;
        logic        eerr;
        logic [7:0]  edat;
        int          roff;
        g      = pick(valid);
        m_last = g;
        ecmd   = cmd[g];
        erh    = rh[g];
        tick();
        chk("req_ready", 32'(req_ready), 32'(1) << g);
        chk("grant_id", 32'(grant_id), 32'(g));
        chk("latched_cmd", 32'(i2c_data), 32'(ecmd));
        chk("latched_ctl", 32'({busy, i2c_exec, i2c_rh_wl, rsp_done}), 32'({1'b1, 1'b0, erh, 3'b000}));
        if (mode == 0) begin
            valid[g] = 1'b0;
        end else if (mode == 2) begin
            valid[g] = 1'($urandom);
            cmd[g]   = 24'($urandom);
            rh[g]    = 1'($urandom);
        end
        if (done_in_issue) i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        chk("exec_pulse", 32'({req_ready, busy, i2c_exec}), 32'(5'b00011));
        ecyc = cyc;
        if (lat >= 0 && lat < TMO) begin
            roff = lat + 1;
            eerr = 1'b0;
            edat = erh ? rdata : 8'h00;
        end else begin
            roff = TMO;
            eerr = 1'b1;
            edat = 8'h00;
        end
        for (int k = 0; k < roff; k++) begin
            if (k == lat) begin
                i2c_done   = 1'b1;
                i2c_data_r = rdata;
            end
            tick();
            i2c_done   = 1'b0;
            i2c_data_r = 8'($urandom);
            if (k < roff - 1) chk("waiting", 32'({rsp_done, busy, i2c_exec}), 32'(5'b00010));
        end
        chk("rsp_done", 32'(rsp_done), 32'(1) << g);
        chk("rsp_err", 32'(rsp_err), 32'(eerr));
        chk("rsp_data_r", 32'(rsp_data_r), 32'(edat));
        chk("rsp_idle", 32'({busy, i2c_exec, i2c_rh_wl}), 32'({1'b0, 1'b0, erh}));
        chk("data_stable", 32'(i2c_data), 32'(ecmd));
    endtask

    initial begin
        int g, e, prev_e, lat;

        // Reset state
        tick(); tick(); tick();
        chk("rst_ctl", 32'({req_ready, rsp_done, rsp_err, i2c_exec, busy, i2c_rh_wl, grant_id}), 32'(0));
        chk("rst_data", {rsp_data_r, i2c_data}, 32'(0));
        rst_n = 1'b1;
        tick();
        chk("idle_quiet", 32'({req_ready, busy, i2c_exec}), 32'(0));

        // Single write on requester 0, completion after 50 cycles
        cmd[0] = 24'h300A00; rh[0] = 1'b0; valid = 3'b001;
        txn(50, 8'h00, 0, 1'b0, g, e);

        // Read return on requester 1
        cmd[1] = 24'h300B00; rh[1] = 1'b1; valid = 3'b010;
        txn(7, 8'h40, 0, 1'b0, g, e);

        // Completion in the exec cycle itself, requester 2
        cmd[2] = 24'h300C55; rh[2] = 1'b0; valid = 3'b100;
        txn(0, 8'h00, 0, 1'b0, g, e);

        // Round-robin with all requesters continuously pending
        cmd[0] = 24'h350101; cmd[1] = 24'h350202; cmd[2] = 24'h350303;
        rh = 3'b010; valid = 3'b111; prev_e = 0;
        for (int i = 0; i < 6; i++) begin
            txn(10, 8'hA0 + 8'(i), (i == 5) ? 0 : 1, 1'b0, g, e);
            chk("rr_order", 32'(grant_id), 32'(i % 3));
            if (i > 0) chk("rr_spacing", 32'(e - prev_e), 32'(13));
            prev_e = e;
        end
        valid = '0;

        // Watchdog expiry, then a normal read
        cmd[0] = 24'h301200; rh[0] = 1'b0; valid = 3'b001;
        txn(-1, 8'h00, 0, 1'b0, g, e);
        cmd[1] = 24'h300B01; rh[1] = 1'b1; valid = 3'b010;
        txn(5, 8'h5A, 0, 1'b0, g, e);

        // Completion coincident with the timeout cycle
        cmd[2] = 24'h3013AA; rh[2] = 1'b1; valid = 3'b100;
        txn(TMO - 1, 8'hC3, 0, 1'b0, g, e);

        // Completion pulse while idle is ignored
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        chk("done_in_idle", 32'({rsp_done, busy, req_ready}), 32'(0));
        tick();
        chk("done_in_idle2", 32'({rsp_done, busy, req_ready}), 32'(0));

        // Completion pulse during the issue cycle is ignored
        cmd[0] = 24'h301400; rh[0] = 1'b1; valid = 3'b001;
        txn(4, 8'h11, 0, 1'b1, g, e);

        // Reset in the middle of a wait, request 0 left pending
        cmd[0] = 24'h301500; rh[0] = 1'b0; valid = 3'b001;
        tick();
        chk("pre_rst_ready", 32'(req_ready), 32'(1));
        tick(); tick(); tick();
        chk("pre_rst_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctl", 32'({req_ready, rsp_done, rsp_err, i2c_exec, busy, i2c_rh_wl, grant_id}), 32'(0));
        chk("rst_async_data", {rsp_data_r, i2c_data}, 32'(0));
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        chk("rst_no_done", 32'({rsp_done, busy}), 32'(0));
        tick();
        rst_n  = 1'b1;
        m_last = NREQ - 1;
        txn(3, 8'h00, 0, 1'b0, g, e);

        // Randomized traffic against the reference model
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!valid[i]) begin
                    cmd[i] = 24'($urandom);
                    rh[i]  = 1'($urandom);
                end
            end
            if (valid == '0) valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 3, TMO + 8))
                                              : int'($urandom_range(0, 30));
            txn(lat, 8'($urandom), 2, ($urandom_range(0, 3) == 0), g, e);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
